// File: rtl/frame_serializer.sv
// Frame serializer: wraps PAYLOAD_BYTES of byte-stream data in a fixed 6-bit header
// and shifts it MSB first onto an idle-high serial line, followed by an idle gap.
module frame_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 128,
  parameter int unsigned GAP_BITS      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output logic [1:0] dbg_state
);

  localparam int unsigned NBITS = PAYLOAD_BYTES * 8;
  localparam int unsigned CW    = $clog2(NBITS);
  localparam int unsigned GW    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [CW-1:0] LAST_BIT  = CW'(NBITS - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(NBITS - 2);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBITS - 8);
  localparam logic [CW-1:0] HDR_LAST  = CW'(5);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, GAP = 2'd3} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    sh_q;
  logic          ser_out_q;
  logic          frame_done_q;
  logic          underrun_q;
  logic          load_slot;
  logic [7:0]    byte_d;

  // Handshake: a byte moves when in_valid && in_ready at a rising edge. in_ready
  // depends only on registered state so the source may look at it before driving.
  always_comb begin
    load_slot = 1'b0;
    case (state_q)
      HDR:     load_slot = (cnt_q == HDR_LAST);
      PAY:     load_slot = (cnt_q[2:0] == 3'd7) && (cnt_q < LAST_BYTE);
      default: load_slot = 1'b0;
    endcase
  end

  // A slot offered without data is filled with all-ones to keep the frame length fixed.
  assign byte_d = in_valid ? in_data : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      sh_q         <= 8'hFF;
      ser_out_q    <= 1'b1;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ser_out_q <= 1'b1;
          if (in_valid) begin
            state_q    <= HDR;
            ser_out_q  <= 1'b0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
          end
        end
        HDR: begin
          if (load_slot) begin
            state_q   <= PAY;
            cnt_q     <= '0;
            sh_q      <= byte_d;
            ser_out_q <= byte_d[7];
            if (!in_valid) underrun_q <= 1'b1;
          end else begin
            // Header 0,1,1,1,1,0: the only 0 after the first bit is bit index 5.
            cnt_q     <= cnt_q + CW'(1);
            ser_out_q <= (cnt_q[2:0] != 3'd4);
          end
        end
        PAY: begin
          if (cnt_q == LAST_BIT) begin
            state_q   <= GAP;
            gap_q     <= '0;
            ser_out_q <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + CW'(1);
            frame_done_q <= (cnt_q == PRE_LAST);
            if (load_slot) begin
              sh_q      <= byte_d;
              ser_out_q <= byte_d[7];
              if (!in_valid) underrun_q <= 1'b1;
            end else begin
              sh_q      <= {sh_q[6:0], 1'b1};
              ser_out_q <= sh_q[6];
            end
          end
        end
        GAP: begin
          ser_out_q <= 1'b1;
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = load_slot;
  assign ser_out    = ser_out_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign dbg_state  = state_q;

endmodule
